// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS controller:
// opcodes, FSM states, datapath mux selects and the control bundle.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd13
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       pc_en;
  } ctrl_t;

endpackage

// File: rtl/mc_out_decode.sv
// Moore output decode of the multicycle controller; only the IR/PC
// enables look at mem_ready and zero.
module mc_out_decode
  import mips_defs::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.pc_en     = zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: next-state, sticky illegal flag and
// retired-instruction counter; outputs come from mc_out_decode.
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             pc_en,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done;
  ctrl_t            ctrl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_TRAP;
        endcase
      end
      // op is expected stable since DECODE; anything else traps
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_TRAP;
      end
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB,
      S_BRANCH, S_JUMP:
                state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state_d == S_FETCH) &&
           (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB,
                            S_ADDIWB, S_BRANCH, S_JUMP});
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, done};
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  mc_out_decode u_dec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign pc_en      = ctrl.pc_en;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected state walks and
// per-state control tables, with random ops, waits and zero flags.
module tb_multicycle_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [5:0]   op = '0;
  logic         zero = 1'b0;
  logic         mem_ready = 1'b0;
  logic         iord, mem_read, mem_write, ir_write;
  logic         reg_dst, reg_write, mem_to_reg, alu_src_a;
  logic [1:0]   alu_src_b, alu_op, pc_source;
  logic         pc_en, illegal;
  logic [3:0]   state;
  logic [W-1:0] retired;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;

  multicycle_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .pc_en(pc_en), .state(state),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs_now();
    return {iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
            mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
            pc_en, illegal};
  endfunction

  // Expected control outputs for each state, straight from the state table
  function automatic logic [16:0] exp_out(int st, bit mr, bit z);
    logic io, rd, wr, irw, dst, rw, m2r, sa, pe, il;
    logic [1:0] sb, ao, ps;
    {io, rd, wr, irw, dst, rw, m2r, sa, pe, il} = '0;
    sb = 0; ao = 0; ps = 0;
    case (st)
      1:  begin rd = 1; sb = 1; irw = mr; pe = mr; end
      2:  sb = 3;
      3:  begin sa = 1; sb = 2; end
      4:  begin rd = 1; io = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin wr = 1; io = 1; end
      7:  begin sa = 1; ao = 2; end
      8:  begin dst = 1; rw = 1; end
      9:  begin sa = 1; ao = 1; ps = 1; pe = z; end
      10: begin ps = 2; pe = 1; end
      11: begin sa = 1; sb = 2; end
      12: rw = 1;
      13: il = 1;
      default: ;
    endcase
    return {io, rd, wr, irw, dst, rw, m2r, sa, sb, ao, ps, pe, il};
  endfunction

  task automatic step(input int st, input bit mr);
    @(negedge clk);
    mem_ready = mr;
    #1;
    n_chk++;
    if (state !== 4'(st)) begin
      n_fail++;
      $display("FAIL state: got %0d want %0d", state, st);
    end
    n_chk++;
    if (outs_now() !== exp_out(st, mr, zero)) begin
      n_fail++;
      $display("FAIL outputs st%0d: got %b want %b",
               st, outs_now(), exp_out(st, mr, zero));
    end
    n_chk++;
    if (retired !== W'(exp_ret)) begin
      n_fail++;
      $display("FAIL retired: got %0d want %0d", retired, exp_ret);
    end
  endtask

  // Walk one instruction starting in FETCH; fw/mw are wait cycles
  task automatic run_instr(input logic [5:0] o, input int fw,
                           input int mw, input bit z);
    op = o;
    zero = z;
    repeat (fw) step(1, 0);
    step(1, 1);
    step(2, 1'($urandom));
    case (o)
      6'b000000: begin step(7, 1'($urandom)); step(8, 1'($urandom)); end
      6'b001000: begin step(11, 1'($urandom)); step(12, 1'($urandom)); end
      6'b000100: step(9, 1'($urandom));
      6'b000010: step(10, 1'($urandom));
      6'b100011: begin
        step(3, 1'($urandom));
        repeat (mw) step(4, 0);
        step(4, 1);
        step(5, 1'($urandom));
      end
      6'b101011: begin
        step(3, 1'($urandom));
        repeat (mw) step(6, 0);
        step(6, 1);
      end
      default: ;
    endcase
    exp_ret = (exp_ret + 1) % (1 << W);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    #1;
    n_chk++;
    if (state !== 4'd0 || outs_now() !== 17'd0 || retired !== '0) begin
      n_fail++;
      $display("FAIL reset: st %0d outs %b ret %0d", state,
               outs_now(), retired);
    end
    repeat (2) @(negedge clk);
    rst = 1;
    exp_ret = 0;
    #1;
    n_chk++;
    if (state !== 4'd0 || outs_now() !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_release: st %0d outs %b want 0", state,
               outs_now());
    end
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(6'b100011, 0, 2, 0);
  endtask

  task automatic test_beq();
    run_instr(6'b000100, 0, 0, 1);
    run_instr(6'b000100, 1, 0, 0);
  endtask

  task automatic test_sw_addi();
    run_instr(6'b101011, 2, 1, 0);
    run_instr(6'b001000, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
            6'b000010, 6'b001000};
    for (int i = 0; i < 40; i++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom));
    step(1, 0);
  endtask

  task automatic test_jump_wrap();
    test_reset();
    for (int i = 0; i < 16; i++) run_instr(6'b000010, 0, 0, 0);
    step(1, 0);
    n_chk++;
    if (retired !== '0) begin
      n_fail++;
      $display("FAIL wrap: retired %0d want 0", retired);
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111;
    step(1, 1);
    step(2, 1'($urandom));
    for (int i = 0; i < 20; i++) step(13, 1'($urandom));
    #2;
    rst = 0;
    #1;
    n_chk++;
    if (illegal !== 1'b0 || state !== 4'd0 || outs_now() !== 17'd0) begin
      n_fail++;
      $display("FAIL illegal_clear: il %b st %0d want 0 0", illegal,
               state);
    end
    @(negedge clk);
    rst = 1;
    exp_ret = 0;
  endtask

  task automatic test_reset_mid_sw();
    op = 6'b101011;
    step(1, 1);
    step(2, 1);
    step(3, 1);
    step(6, 0);
    step(6, 0);
    #2;
    rst = 0;
    #1;
    n_chk++;
    if (mem_write !== 1'b0 || state !== 4'd0 || outs_now() !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_sw_abort: mem_write %b st %0d want 0 0",
               mem_write, state);
    end
    @(negedge clk);
    rst = 1;
    exp_ret = 0;
    #1;
    n_chk++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_sw_idle: st %0d want 0", state);
    end
    run_instr(6'b000010, 0, 0, 0);
    step(1, 0);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_addi();
    test_random();
    test_jump_wrap();
    test_illegal();
    test_reset_mid_sw();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
